mem_fetch_ctrl: RTL

MEM_FETCH_CTRL -- requirements
Module: mem_fetch_ctrl

---
 rtl/mem_fetch_ctrl_pkg.sv | 29 ++
 rtl/mem_fetch_pc.sv | 35 +++
 rtl/mem_fetch_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mem_fetch_ctrl_pkg.sv
// Shared constants, instruction field positions and FSM state encoding
// for the fetch/decode controller and its program counter.
package mem_fetch_ctrl_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  localparam logic [2:0] OPC_REG = 3'b111;

  // Instruction word layout: [7] indirect, [6:4] opcode, [3:0] address field.
  localparam int IND_BIT = 7;
  localparam int OPC_MSB = 6;
  localparam int OPC_LSB = 4;
  localparam int ADR_MSB = 3;
  localparam int ADR_LSB = 0;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    FETCH   = 4'd1,
    FETCH_W = 4'd2,
    IND     = 4'd3,
    IND_W   = 4'd4,
    OPND    = 4'd5,
    OPND_W  = 4'd6,
    STORE   = 4'd7,
    DONE    = 4'd8
  } state_e;

endpackage

// File: rtl/mem_fetch_pc.sv
// Program counter: parallel load has priority over increment; wraps at 2**ADDR_W.
module mem_fetch_pc
  import mem_fetch_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_val_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_val_i;
    end else if (inc_i) begin
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/mem_fetch_ctrl.sv
// Instruction fetch/decode controller with direct, indirect and register-reference
// addressing plus a single-cycle store; RAM has one cycle of read latency.
module mem_fetch_ctrl
  import mem_fetch_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [2:0]        opcode,
  output logic              indirect,
  output logic [ADDR_W-1:0] eff_addr,
  output logic [DATA_W-1:0] operand,
  output logic [ADDR_W-1:0] pc,
  output logic [3:0]        dbg_state
);

  state_e            state_q, state_d;
  logic [2:0]        opcode_q, opcode_d;
  logic              indirect_q, indirect_d;
  logic [ADDR_W-1:0] eff_addr_q, eff_addr_d;
  logic [DATA_W-1:0] operand_q, operand_d;
  logic              pc_load_en;
  logic              pc_inc;

  mem_fetch_pc u_pc (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (pc_load_en),
    .load_val_i (pc_in),
    .inc_i      (pc_inc),
    .pc_o       (pc)
  );

  // Strobes are decoded from state alone so an async reset drops them at once.
  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    indirect_d = indirect_q;
    eff_addr_d = eff_addr_q;
    operand_d  = operand_q;
    pc_load_en = 1'b0;
    pc_inc     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (pc_load) begin
          pc_load_en = 1'b1;
        end else if (start) begin
          state_d = FETCH;
        end else if (wr_req) begin
          state_d = STORE;
        end
      end
      FETCH: begin
        mem_read = 1'b1;
        mem_addr = pc;
      end
      FETCH_W: begin
        // eff_addr doubles as the pointer address while an indirect fetch is pending.
        opcode_d   = mem_rdata[OPC_MSB:OPC_LSB];
        indirect_d = mem_rdata[IND_BIT];
        eff_addr_d = mem_rdata[ADR_MSB:ADR_LSB];
        pc_inc     = 1'b1;
        if (mem_rdata[OPC_MSB:OPC_LSB] == OPC_REG) begin
          operand_d = '0;
          state_d   = DONE;
        end else if (mem_rdata[IND_BIT]) begin
          state_d = IND;
        end else begin
          state_d = OPND;
        end
      end
      IND: begin
        mem_read = 1'b1;
        mem_addr = eff_addr_q;
      end
      IND_W: begin
        eff_addr_d = mem_rdata[ADR_MSB:ADR_LSB];
        state_d    = OPND;
      end
      OPND: begin
        mem_read = 1'b1;
        mem_addr = eff_addr_q;
      end
      OPND_W: begin
        operand_d = mem_rdata;
        state_d   = DONE;
      end
      STORE: begin
        mem_write = 1'b1;
        mem_addr  = eff_addr_q;
        mem_wdata = wr_data;
        state_d   = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Each request state hands over to its own wait state.
    if (state_q == FETCH) state_d = FETCH_W;
    if (state_q == IND)   state_d = IND_W;
    if (state_q == OPND)  state_d = OPND_W;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      opcode_q   <= '0;
      indirect_q <= 1'b0;
      eff_addr_q <= '0;
      operand_q  <= '0;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      indirect_q <= indirect_d;
      eff_addr_q <= eff_addr_d;
      operand_q  <= operand_d;
    end
  end

  assign opcode    = opcode_q;
  assign indirect  = indirect_q;
  assign eff_addr  = eff_addr_q;
  assign operand   = operand_q;
  assign dbg_state = state_q;

endmodule
